// File: rtl/fetch_pkg.sv
// Shared constants, prefetch entry type and PC-step helper for the fetch front end.
package fetch_pkg;

  localparam int          FETCH_ADDR_W     = 32;
  localparam int          FETCH_INSTR_W    = 16;
  localparam int          FETCH_FIFO_DEPTH = 4;
  localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fifo_entry_t;

  // Byte distance between consecutive instructions.
  function automatic int pc_step(input int instr_w);
    return instr_w / 8;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush, occupancy count and async active-high reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_FIFO_DEPTH,
  parameter type entry_t = fifo_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled, redirectable instruction fetch stage feeding decode over ready/valid.
// Optional FETCH_BYPASS_EN: a live response is forwarded to decode while the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter int                INSTR_W    = FETCH_INSTR_W,
  parameter int                FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_next
);

  localparam int                CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int                OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(pc_step(INSTR_W));

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;

  logic              issue;
  logic              kill;
  logic              rsp_live;
  logic              bypass;
  logic              push;
  logic              pop;
  entry_t            push_data;
  entry_t            head;
  entry_t            sel;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  // Every outstanding read owns a FIFO slot, so the buffer can never overflow.
  assign issue = !reset && !redirect_valid && !full &&
                 (({1'b0, count} + OCC_W'(vld_p1)) < OCC_W'(FIFO_DEPTH));

  assign imem_rd_en = issue;
  assign imem_addr  = pc_p0;

  // Stage p0: PC register and read issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0  <= RESET_PC;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (redirect_valid)
        pc_p0 <= redirect_pc & ~ADDR_W'(1);
      else if (issue)
        pc_p0 <= pc_p0 + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= pc_p0;
  end

  // Stage p1: response capture. A read that returns during a redirect belongs to the old path.
  assign kill     = vld_p1 && redirect_valid;
  assign rsp_live = vld_p1 && !kill;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_live && empty;
`else
  assign bypass = 1'b0;
`endif

  assign push_data = '{pc: pc_p1, instr: imem_rdata};
  assign sel       = bypass ? push_data : head;

  assign out_valid   = !redirect_valid && (!empty || bypass);
  assign out_instr   = out_valid ? sel.instr : '0;
  assign out_pc      = out_valid ? sel.pc : '0;
  assign out_pc_next = out_valid ? (sel.pc + STEP) : '0;

  // A forwarded response that decode takes immediately never enters the buffer.
  assign push = rsp_live && !(bypass && out_ready);
  assign pop  = out_valid && out_ready && !bypass;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .flush     (redirect_valid),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;

  logic        w_rd_en;
  logic [31:0] w_addr;
  logic [15:0] w_rdata;
  logic        w_valid;
  logic [15:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc_next;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .INSTR_W(16), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next)
  );

  fetch_unit #(.ADDR_W(32), .INSTR_W(16), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFE)) dut_w (
    .clk(clk), .reset(reset),
    .imem_rd_en(w_rd_en), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_valid), .out_ready(1'b1), .out_instr(w_instr),
    .out_pc(w_pc), .out_pc_next(w_pc_next)
  );

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 1) + 32'h1000;
    return w[15:0];
  endfunction

  // One-cycle memories; idle cycles return noise.
  always @(posedge clk) begin
    imem_rdata <= imem_rd_en ? mem_word(imem_addr) : 16'($urandom);
    w_rdata    <= w_rd_en ? mem_word(w_addr) : 16'($urandom);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected delivery stream and expected issue stream.
  logic [31:0] exp_pc, iss_pc, nxt;
  int          pend;
  int          n_hs;
  bit          hold_chk;
  logic [31:0] hold_pc;
  logic [15:0] hold_instr;
  logic        s_rd, s_valid;
  logic [31:0] s_addr, s_pc;
  logic [31:0] w_pcs [2];
  logic [31:0] w_nexts [2];
  logic [15:0] w_instrs [2];
  int          w_n = 0;

  task automatic model_reset();
    exp_pc   = 32'h0;
    iss_pc   = 32'h0;
    pend     = 0;
    hold_chk = 0;
  endtask

  task automatic step();
    @(negedge clk);
    s_rd = imem_rd_en; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc;
    if (hold_chk && !redirect_valid) begin
      check("hold_vld", out_valid, 1'b1);
      check("hold_pc", out_pc, hold_pc);
      check("hold_instr", out_instr, hold_instr);
    end
    check("issue", imem_rd_en, !redirect_valid && (pend < DEPTH));
    if (imem_rd_en) begin
      check("rd_addr", imem_addr, iss_pc);
      iss_pc = iss_pc + 32'd2;
      pend++;
    end
    if (redirect_valid) begin
      check("rdr_vld", out_valid, 1'b0);
      exp_pc = {redirect_pc[31:1], 1'b0};
      iss_pc = exp_pc;
      pend   = 0;
    end else if (out_valid && out_ready) begin
      nxt = exp_pc + 32'd2;
      check("out_pc", out_pc, exp_pc);
      check("out_instr", out_instr, mem_word(exp_pc));
      check("out_pc_next", out_pc_next, nxt);
      exp_pc = nxt;
      pend--;
      n_hs++;
    end
    hold_chk   = out_valid && !out_ready && !redirect_valid;
    hold_pc    = out_pc;
    hold_instr = out_instr;
    if (w_valid && w_n < 2) begin
      w_pcs[w_n] = w_pc; w_nexts[w_n] = w_pc_next; w_instrs[w_n] = w_instr;
      w_n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_rd, first_v, hs0, guard;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    n_hs = 0;
    model_reset();
    #12;
    check("rst_rd_en", imem_rd_en, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_instr", out_instr, 16'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_pc_next", out_pc_next, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First-fetch latency and initial stream.
    first_rd = -1; first_v = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_rd && first_rd < 0) first_rd = i;
      if (s_valid && first_v < 0) first_v = i;
    end
    check("first_latency", 64'(first_v - first_rd), 64'(LAT));
    check("first_hs_cnt", n_hs >= 4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("throughput", s_valid, 1'b1);
    end

    // Backpressure fills the buffer and stops issue.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("stall_rd_en", s_rd, 1'b0);
    check("stall_occ", pend, DEPTH);
    out_ready = 1'b1;
    hs0 = n_hs;
    for (int i = 0; i < 10; i++) step();
    check("drain_hs", n_hs - hs0 >= 5, 1'b1);

    // Redirect while three entries are buffered and one read is outstanding.
    out_ready = 1'b0;
    guard = 0;
    while (pend < DEPTH && guard < 20) begin step(); guard++; end
    check("fill_guard", guard < 20, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h101;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    check("rdr_issue", s_rd, 1'b1);
    check("rdr_addr", s_addr, 32'h100);
    for (int i = 0; i < LAT - 1; i++) begin
      step();
      check("rdr_early_vld", s_valid, 1'b0);
    end
    step();
    check("rdr_tgt_vld", s_valid, 1'b1);
    check("rdr_tgt_pc", s_pc, 32'h100);

    // Randomized ready and redirect traffic.
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check("arst_rd_en", imem_rd_en, 1'b0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_pc", out_pc, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step();
    check("restart_rd", s_rd, 1'b1);
    check("restart_addr", s_addr, 32'h0);
    hs0 = n_hs;
    for (int i = 0; i < 6; i++) step();
    check("restart_hs", n_hs - hs0 >= 4, 1'b1);

    // PC wrap instance.
    check("wrap_cnt", w_n, 2);
    check("wrap_pc0", w_pcs[0], 32'hFFFF_FFFE);
    check("wrap_next0", w_nexts[0], 32'h0);
    check("wrap_instr0", w_instrs[0], mem_word(32'hFFFF_FFFE));
    check("wrap_pc1", w_pcs[1], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
